// File: rtl/i2s_tx_if.sv
// +----------------------------------------------------------------------------+
// | i2s_tx_if : stereo sample handshake between the volume stage and i2s_tx    |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface i2s_tx_if #(
  parameter int SMP_W = 16
);
  logic [SMP_W-1:0] lft_in;
  logic [SMP_W-1:0] rht_in;
  logic             smp_vld;
  logic             smp_rdy;

  modport master (
    output lft_in,
    output rht_in,
    output smp_vld,
    input  smp_rdy
  );

  modport slave (
    input  lft_in,
    input  rht_in,
    input  smp_vld,
    output smp_rdy
  );
endinterface

`default_nettype wire

// File: rtl/i2s_tx.sv
// +----------------------------------------------------------------------------+
// | i2s_tx   : I2S transmitter, codec clock/reset generation, double-buffered  |
// |            stereo serializer. Build option: I2S_UNDERRUN_ZERO_EN           |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module i2s_tx #(
  parameter int SMP_W    = 16,
  parameter int RSTN_DLY = 1024
) (
  input  logic      clk,
  input  logic      rst,
  i2s_tx_if.slave   smp_if,
  output logic      MCLK,
  output logic      SCLK,
  output logic      LRCLK,
  output logic      SDin,
  output logic      RSTn,
  output logic      underrun
);

  localparam int                   RST_CNT_W   = (RSTN_DLY < 1) ? 1 : $clog2(RSTN_DLY + 1);
  localparam logic [RST_CNT_W-1:0] RST_CNT_MAX = RST_CNT_W'(RSTN_DLY);
  localparam logic [10:0]          CNT_WRAP    = 11'd2047;

  logic [10:0]          cnt_q, cnt_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic                 rstn_q, rstn_d;
  logic [SMP_W-1:0]     pend_lft_q, pend_lft_d;
  logic [SMP_W-1:0]     pend_rht_q, pend_rht_d;
  logic                 pend_full_q, pend_full_d;
  logic [SMP_W-1:0]     act_lft_q, act_lft_d;
  logic [SMP_W-1:0]     act_rht_q, act_rht_d;
  logic                 smp_rdy_q, smp_rdy_d;
  logic                 underrun_q, underrun_d;
  logic                 sdin_q, sdin_d;

  logic                 frame_start;
  logic                 accept;
  logic [4:0]           bit_pos;
  logic [4:0]           slot_idx;
  logic [SMP_W-1:0]     tx_smp;
  logic [31:0]          slot;

  always_comb begin
    cnt_d       = cnt_q + 11'd1;
    frame_start = (cnt_q == CNT_WRAP);
    accept      = smp_if.smp_vld & smp_rdy_q;

    rst_cnt_d = (rst_cnt_q == RST_CNT_MAX) ? rst_cnt_q : rst_cnt_q + RST_CNT_W'(1);
    rstn_d    = rstn_q | (rst_cnt_q == RST_CNT_MAX);

    pend_lft_d  = pend_lft_q;
    pend_rht_d  = pend_rht_q;
    pend_full_d = pend_full_q;
    act_lft_d   = act_lft_q;
    act_rht_d   = act_rht_q;
    underrun_d  = 1'b0;

    // Transfer decision uses the pre-edge pend_full, so a pair accepted on the
    // boundary edge always waits for the following frame.
    if (frame_start) begin
      if (pend_full_q) begin
        act_lft_d   = pend_lft_q;
        act_rht_d   = pend_rht_q;
        pend_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
`ifdef I2S_UNDERRUN_ZERO_EN
        act_lft_d  = '0;
        act_rht_d  = '0;
`endif
      end
    end

    if (accept) begin
      pend_lft_d  = smp_if.lft_in;
      pend_rht_d  = smp_if.rht_in;
      pend_full_d = 1'b1;
    end

    smp_rdy_d = ~pend_full_d;

    // Sample sits left-justified in a 32-bit slot; slot bit (32-p) is sent at
    // position p, and the zero padding covers both p=0 and p>SMP_W.
    bit_pos  = cnt_d[9:5];
    slot_idx = 5'd0 - bit_pos;
    tx_smp   = cnt_d[10] ? act_rht_q : act_lft_q;
    slot     = {tx_smp, {(32-SMP_W){1'b0}}};

    sdin_d = sdin_q;
    if (cnt_d[4:0] == 5'd0) begin
      sdin_d = (bit_pos == 5'd0) ? 1'b0 : slot[slot_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rst_cnt_q   <= '0;
      rstn_q      <= 1'b0;
      pend_lft_q  <= '0;
      pend_rht_q  <= '0;
      pend_full_q <= 1'b0;
      act_lft_q   <= '0;
      act_rht_q   <= '0;
      smp_rdy_q   <= 1'b0;
      underrun_q  <= 1'b0;
      sdin_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      rstn_q      <= rstn_d;
      pend_lft_q  <= pend_lft_d;
      pend_rht_q  <= pend_rht_d;
      pend_full_q <= pend_full_d;
      act_lft_q   <= act_lft_d;
      act_rht_q   <= act_rht_d;
      smp_rdy_q   <= smp_rdy_d;
      underrun_q  <= underrun_d;
      sdin_q      <= sdin_d;
    end
  end

  assign MCLK           = cnt_q[1];
  assign SCLK           = cnt_q[4];
  assign LRCLK          = cnt_q[10];
  assign SDin           = sdin_q;
  assign RSTn           = rstn_q;
  assign underrun       = underrun_q;
  assign smp_if.smp_rdy = smp_rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// +----------------------------------------------------------------------------+
// | tb_i2s_tx : self-checking bench for i2s_tx against a frame-level model     |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_i2s_tx;
  localparam int SMP_W    = 16;
  localparam int RSTN_DLY = 1024;

  logic clk;
  logic rst;
  logic mclk, sclk, lrclk, sdin, rstn, underrun;

  i2s_tx_if #(.SMP_W(SMP_W)) ifc ();

  i2s_tx #(.SMP_W(SMP_W), .RSTN_DLY(RSTN_DLY)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .smp_if   (ifc),
    .MCLK     (mclk),
    .SCLK     (sclk),
    .LRCLK    (lrclk),
    .SDin     (sdin),
    .RSTn     (rstn),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Reference state: position in frame, pending slot, pair owning the current frame.
  int               cnt_m;
  int               since_rel;
  bit               pend_full_m;
  logic [SMP_W-1:0] pend_l_m, pend_r_m;
  logic [SMP_W-1:0] act_l_m, act_r_m;
  bit               rdy_m, und_m, rstn_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic exp_sdin(input int c, input logic [SMP_W-1:0] l, input logic [SMP_W-1:0] r);
    int               p;
    logic [SMP_W-1:0] s;
    p = (c / 32) % 32;
    s = (c >= 1024) ? r : l;
    if (p >= 1 && p <= SMP_W) return s[SMP_W-p];
    return 1'b0;
  endfunction

  task automatic tick(input bit r, input bit v, input logic [SMP_W-1:0] l, input logic [SMP_W-1:0] rr);
    bit boundary;
    bit acc;
    rst         = r;
    ifc.smp_vld = v;
    ifc.lft_in  = l;
    ifc.rht_in  = rr;
    if (r) begin
      cnt_m       = 0;
      since_rel   = 0;
      pend_full_m = 1'b0;
      pend_l_m    = '0;
      pend_r_m    = '0;
      act_l_m     = '0;
      act_r_m     = '0;
      rdy_m       = 1'b0;
      und_m       = 1'b0;
      rstn_m      = 1'b0;
    end else begin
      boundary = (cnt_m == 2047);
      acc      = v && rdy_m;
      und_m    = boundary && !pend_full_m;
      if (boundary) begin
        if (pend_full_m) begin
          act_l_m     = pend_l_m;
          act_r_m     = pend_r_m;
          pend_full_m = 1'b0;
        end else begin
`ifdef I2S_UNDERRUN_ZERO_EN
          act_l_m = '0;
          act_r_m = '0;
`endif
        end
      end
      if (acc) begin
        pend_l_m    = l;
        pend_r_m    = rr;
        pend_full_m = 1'b1;
      end
      rdy_m     = !pend_full_m;
      cnt_m     = (cnt_m + 1) % 2048;
      since_rel = since_rel + 1;
      rstn_m    = (since_rel > RSTN_DLY);
    end
    @(negedge clk);
    cyc++;
    chk("MCLK",     32'(mclk),        32'((cnt_m >> 1) & 1));
    chk("SCLK",     32'(sclk),        32'((cnt_m >> 4) & 1));
    chk("LRCLK",    32'(lrclk),       32'(cnt_m >= 1024));
    chk("SDin",     32'(sdin),        32'(exp_sdin(cnt_m, act_l_m, act_r_m)));
    chk("RSTn",     32'(rstn),        32'(rstn_m));
    chk("smp_rdy",  32'(ifc.smp_rdy), 32'(rdy_m));
    chk("underrun", 32'(underrun),    32'(und_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, SMP_W'($urandom), SMP_W'($urandom));
  endtask

  task automatic wait_cnt(input int target);
    int guard = 0;
    while (cnt_m != target && guard < 4096) begin
      idle(1);
      guard++;
    end
  endtask

  task automatic push(input logic [SMP_W-1:0] l, input logic [SMP_W-1:0] r);
    int waited = 0;
    bit took;
    forever begin
      took = rdy_m;
      tick(1'b0, 1'b1, l, r);
      if (took) return;
      waited++;
      if (waited > 4200) begin
        n_checks++;
        n_errs++;
        $display("FAIL push_wait: got %0d cycles want <=4200 (cycle %0d)", waited, cyc);
        return;
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    ifc.smp_vld = 1'b0;
    ifc.lft_in  = '0;
    ifc.rht_in  = '0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, '0, '0);

    // Single pair pushed at cnt=100 of the first frame.
    wait_cnt(100);
    push(16'hA5C3, 16'h1234);
    idle(4300);

    // Three back-to-back pairs under backpressure.
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    push(16'h5555, 16'h6666);
    idle(4300);

    // Randomized traffic at varying rates, including idle stretches.
    for (int seg = 0; seg < 10; seg++) begin
      int mode;
      int stop;
      mode = $urandom_range(0, 3);
      stop = cyc + 2000;
      while (cyc < stop) begin
        if (mode != 0 && $urandom_range(0, 3 * mode) == 0)
          push(SMP_W'($urandom), SMP_W'($urandom));
        else
          idle(1);
      end
    end
    idle(4300);

    // Last pair then starvation: repeat or silence depending on build.
    push(16'h7FFF, 16'h8001);
    idle(4300);

    // Pair offered exactly on the wrap edge with the pending slot empty.
    wait_cnt(2047);
    tick(1'b0, 1'b1, 16'hC0DE, 16'h0BAD);
    idle(4300);

    // Reset mid-frame while a pair is pending.
    wait_cnt(650);
    push(16'hDEAD, 16'hBEEF);
    wait_cnt(700);
    tick(1'b1, 1'b0, '0, '0);
    idle(2300);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
